// File: rtl/uart_pixel_ctrl.sv
// uart_pixel_ctrl
//   Packet controller between the UART receiver and the Neopixel pixel
//   store/driver. Parses pixel-write packets (A5 idx G R B chk) and show
//   commands (5A), validates index range and XOR checksum, issues one-cycle
//   pixel-memory writes and holds refresh requests until the driver is idle.
//   Stalled or corrupt packets are discarded and counted (saturating).
//
// Parameters
//   NUM_PIXELS   : number of addressable pixels (valid index 0..NUM_PIXELS-1)
//   ADDR_W       : pixel address width, 2**ADDR_W >= NUM_PIXELS
//   TIMEOUT_CLKS : idle clocks allowed between bytes inside a packet
//
// Ports
//   i_clk       : system clock, rising edge
//   i_reset     : asynchronous active-high reset
//   i_rx_byte   : received byte, valid while i_rx_valid is high
//   i_rx_valid  : one-cycle byte strobe from the UART receiver
//   i_drv_busy  : pixel driver is shifting a frame
//   o_wr_en     : one-cycle pixel-memory write strobe
//   o_wr_addr   : pixel index for the write (held until the next write)
//   o_wr_data   : pixel colour {G,R,B} (held until the next write)
//   o_show      : one-cycle refresh start to the driver
//   o_err_count : saturating count of dropped packets
module uart_pixel_ctrl #(
  parameter int unsigned NUM_PIXELS   = 8,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned TIMEOUT_CLKS = 26040
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_rx_valid,
  input  logic              i_drv_busy,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [23:0]       o_wr_data,
  output logic              o_show,
  output logic [7:0]        o_err_count
);

  localparam int unsigned CNT_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] CMD_PKT  = 8'hA5;
  localparam logic [7:0] CMD_SHOW = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE, S_INDEX, S_GREEN, S_RED, S_BLUE, S_CHECK
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          idx_q, idx_d;
  logic [7:0]          g_q, g_d, r_q, r_d, b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [23:0]         data_q, data_d;
  logic                show_q, show_d;
  logic [7:0]          err_q, err_d;
  logic                err_inc;
  logic                show_req;
  logic                pkt_ok;

  // Full 8-bit index is range-checked, not just the address bits.
  assign pkt_ok = (i_rx_byte == (idx_q ^ g_q ^ r_q ^ b_q)) &&
                  (32'(idx_q) < NUM_PIXELS);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    g_d      = g_q;
    r_d      = r_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    err_inc  = 1'b0;
    show_req = pend_q;

    if (i_rx_valid) begin
      // An accepted byte always restarts the inter-byte timer, even in the
      // cycle the timer would otherwise expire.
      cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (i_rx_byte == CMD_PKT)       state_d = S_INDEX;
          else if (i_rx_byte == CMD_SHOW) show_req = 1'b1;
        end
        S_INDEX: begin idx_d = i_rx_byte; state_d = S_GREEN; end
        S_GREEN: begin g_d   = i_rx_byte; state_d = S_RED;   end
        S_RED:   begin r_d   = i_rx_byte; state_d = S_BLUE;  end
        S_BLUE:  begin b_d   = i_rx_byte; state_d = S_CHECK; end
        S_CHECK: begin
          state_d = S_IDLE;
          if (pkt_ok) begin
            wr_en_d = 1'b1;
            addr_d  = idx_q[ADDR_W-1:0];
            data_d  = {g_q, r_q, b_q};
          end else begin
            err_inc = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        err_inc = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end

    // A new 5A and an already-pending request merge into one show; the
    // request is held while the driver is busy.
    show_d = show_req && !i_drv_busy;
    pend_d = show_req && i_drv_busy;
    err_d  = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      g_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      show_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      g_q     <= g_d;
      r_q     <= r_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      show_q  <= show_d;
      err_q   <= err_d;
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = addr_q;
  assign o_wr_data   = data_q;
  assign o_show      = show_q;
  assign o_err_count = err_q;

endmodule

// File: tb/tb_uart_pixel_ctrl.sv
module tb_uart_pixel_ctrl;

  localparam int unsigned NPIX = 8;
  localparam int unsigned AW   = 3;
  localparam int unsigned TO   = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          show;
  logic [7:0]    err_count;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int show_seen = 0;
  int exp_err = 0;

  uart_pixel_ctrl #(
    .NUM_PIXELS  (NPIX),
    .ADDR_W      (AW),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_rx_byte  (rx_byte),
    .i_rx_valid (rx_valid),
    .i_drv_busy (busy),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_show     (show),
    .o_err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wr_seen++;
    if (show)  show_seen++;
  end

  // Reference: packet accepted iff XOR checksum matches and index in range.
  function automatic bit model_ok(input logic [7:0] idx, g, r, b, chk);
    return (chk == (idx ^ g ^ r ^ b)) && (int'(idx) < int'(NPIX));
  endfunction

  function automatic int model_err_inc(input int e);
    return (e >= 255) ? 255 : e + 1;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    #1 rx_byte = b; rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0; rx_byte = 8'($urandom);
  endtask

  task automatic send_pkt(input logic [7:0] idx, g, r, b, chk, input int gap);
    send_byte(8'hA5, gap);
    send_byte(idx, gap);
    send_byte(g, gap);
    send_byte(r, gap);
    send_byte(b, gap);
    send_byte(chk, gap);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_valid = 1'b0; busy = 1'b0; rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wr_en !== 1'b0)        begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (show !== 1'b0)         begin errors++; $display("FAIL reset_show: got %b want 0", show); end
    checks++; if (wr_addr !== '0)        begin errors++; $display("FAIL reset_addr: got %0h want 0", wr_addr); end
    checks++; if (wr_data !== '0)        begin errors++; $display("FAIL reset_data: got %0h want 0", wr_data); end
    checks++; if (err_count !== 8'd0)    begin errors++; $display("FAIL reset_err: got %0d want 0", err_count); end
    @(negedge clk) rst = 1'b0;
    exp_err = 0;
  endtask

  task automatic test_valid_write;
    send_pkt(8'h03, 8'h10, 8'h20, 8'h30, 8'h03, 0);
    checks++; if (wr_en !== 1'b1)          begin errors++; $display("FAIL write_en: got %b want 1", wr_en); end
    checks++; if (wr_addr !== 3'd3)        begin errors++; $display("FAIL write_addr: got %0d want 3", wr_addr); end
    checks++; if (wr_data !== 24'h102030)  begin errors++; $display("FAIL write_data: got %0h want 102030", wr_data); end
    checks++; if (err_count !== 8'd0)      begin errors++; $display("FAIL write_err: got %0d want 0", err_count); end
    @(posedge clk); #1;
    checks++; if (wr_en !== 1'b0)          begin errors++; $display("FAIL write_pulse_len: got %b want 0", wr_en); end
    checks++; if (wr_data !== 24'h102030)  begin errors++; $display("FAIL write_hold: got %0h want 102030", wr_data); end
  endtask

  task automatic test_bad_packets;
    send_pkt(8'h03, 8'h10, 8'h20, 8'h30, 8'h04, 0);
    exp_err = model_err_inc(exp_err);
    checks++; if (wr_en !== 1'b0)            begin errors++; $display("FAIL badchk_wr: got %b want 0", wr_en); end
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL badchk_err: got %0d want %0d", err_count, exp_err); end
    send_pkt(8'h08, 8'h00, 8'h00, 8'h00, 8'h08, 1);
    exp_err = model_err_inc(exp_err);
    checks++; if (wr_en !== 1'b0)            begin errors++; $display("FAIL badidx_wr: got %b want 0", wr_en); end
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL badidx_err: got %0d want %0d", err_count, exp_err); end
  endtask

  task automatic test_garbage;
    logic [7:0] g [3];
    int base;
    g[0] = 8'h00; g[1] = 8'h5B; g[2] = 8'hFF;
    base = wr_seen;
    foreach (g[i]) begin
      send_byte(g[i], 0);
      checks++; if (show !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL garbage_out: got show=%b wr=%b want 0", show, wr_en); end
    end
    @(posedge clk); #1;
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL garbage_err: got %0d want %0d", err_count, exp_err); end
    checks++; if (wr_seen != base)           begin errors++; $display("FAIL garbage_wr: got %0d writes want 0", wr_seen - base); end
  endtask

  task automatic test_show;
    int base;
    send_byte(8'h5A, 0);
    checks++; if (show !== 1'b1) begin errors++; $display("FAIL show_idle: got %b want 1", show); end
    @(posedge clk); #1;
    busy = 1'b1;
    base = show_seen;
    send_byte(8'h5A, 0);
    send_byte(8'h5A, 2);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (show_seen != base) begin errors++; $display("FAIL show_busy_held: got %0d pulses want 0", show_seen - base); end
    busy = 1'b0;
    @(negedge clk);
    checks++; if (show !== 1'b0) begin errors++; $display("FAIL show_early: got %b want 0", show); end
    @(posedge clk); #1;
    checks++; if (show !== 1'b1) begin errors++; $display("FAIL show_release: got %b want 1", show); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (show_seen - base != 1) begin errors++; $display("FAIL show_merge: got %0d pulses want 1", show_seen - base); end
  endtask

  task automatic test_timeout;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    repeat (TO - 1) @(posedge clk);
    #1;
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL timeout_early: got %0d want %0d", err_count, exp_err); end
    @(posedge clk); #1;
    exp_err = model_err_inc(exp_err);
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL timeout_abort: got %0d want %0d", err_count, exp_err); end
    send_pkt(8'h01, 8'hFF, 8'h00, 8'h00, 8'hFE, 0);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 3'd1 || wr_data !== 24'hFF0000)
      begin errors++; $display("FAIL timeout_recover: got wr=%b a=%0d d=%0h want 1/1/ff0000", wr_en, wr_addr, wr_data); end
    // Longest gap that must still be accepted inside a packet.
    send_byte(8'hA5, 0);
    send_byte(8'h05, 0);
    send_byte(8'h11, TO - 1);
    send_byte(8'h22, TO - 1);
    send_byte(8'h33, 0);
    send_byte(8'h05, TO - 1);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 3'd5 || wr_data !== 24'h112233)
      begin errors++; $display("FAIL timeout_boundary: got wr=%b a=%0d d=%0h want 1/5/112233", wr_en, wr_addr, wr_data); end
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL timeout_boundary_err: got %0d want %0d", err_count, exp_err); end
  endtask

  task automatic test_reset_mid;
    int base;
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    #2 rst = 1'b1;
    #1;
    checks++; if (wr_addr !== '0 || wr_data !== '0 || err_count !== 8'd0 || wr_en !== 1'b0 || show !== 1'b0)
      begin errors++; $display("FAIL reset_async: got a=%0h d=%0h e=%0d wr=%b sh=%b want 0", wr_addr, wr_data, err_count, wr_en, show); end
    @(negedge clk) rst = 1'b0;
    exp_err = 0;
    base = wr_seen;
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h00, 0);
    @(posedge clk); #1;
    checks++; if (wr_seen != base)   begin errors++; $display("FAIL reset_nowrite: got %0d writes want 0", wr_seen - base); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_after_err: got %0d want 0", err_count); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 300; i++) begin
      send_pkt(8'($urandom_range(0, 7)), 8'h00, 8'h00, 8'h00, 8'hF0, 0);
      exp_err = model_err_inc(exp_err);
    end
    checks++; if (err_count !== 8'(exp_err) || exp_err != 255)
      begin errors++; $display("FAIL saturation: got %0d want 255", err_count); end
  endtask

  task automatic test_random;
    logic [7:0] idx, g, r, b, chk;
    int kind, gap;
    bit ok;
    rst = 1'b1; #3 rst = 1'b0;
    exp_err = 0;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 4);
      gap  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 3);
      g = 8'($urandom); r = 8'($urandom); b = 8'($urandom);
      if (kind == 3) begin
        send_byte(8'h5A, gap);
        checks++; if (show !== 1'b1) begin errors++; $display("FAIL rand_show[%0d]: got %b want 1", n, show); end
      end else if (kind == 4) begin
        do chk = 8'($urandom); while (chk == 8'hA5 || chk == 8'h5A);
        send_byte(chk, gap);
        checks++; if (wr_en !== 1'b0 || show !== 1'b0 || err_count !== 8'(exp_err))
          begin errors++; $display("FAIL rand_garbage[%0d]: got wr=%b sh=%b e=%0d want 0/0/%0d", n, wr_en, show, err_count, exp_err); end
      end else begin
        idx = (kind == 2) ? 8'($urandom_range(NPIX, 255)) : 8'($urandom_range(0, NPIX - 1));
        chk = idx ^ g ^ r ^ b;
        if (kind == 1) chk = chk ^ 8'($urandom_range(1, 255));
        send_pkt(idx, g, r, b, chk, gap);
        ok = model_ok(idx, g, r, b, chk);
        if (!ok) exp_err = model_err_inc(exp_err);
        checks++; if (wr_en !== ok) begin errors++; $display("FAIL rand_wr_en[%0d]: got %b want %b", n, wr_en, ok); end
        if (ok) begin
          checks++; if (wr_addr !== idx[AW-1:0] || wr_data !== {g, r, b})
            begin errors++; $display("FAIL rand_wr_data[%0d]: got a=%0d d=%0h want a=%0d d=%0h", n, wr_addr, wr_data, idx[AW-1:0], {g, r, b}); end
        end
        checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL rand_err[%0d]: got %0d want %0d", n, err_count, exp_err); end
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_valid_write();
    test_bad_packets();
    test_garbage();
    test_show();
    test_timeout();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
